// File: rtl/tlk_error_monitor_if.sv
// Bus bundle for tlk_error_monitor: TLK error strobes, per-channel status and the read port.
// The master modport drives the strobes and read requests; the slave modport is the monitor.
interface tlk_error_monitor_if #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]   err_in;
  logic [N_CH-1:0]   send_err;
  logic              clr_cnt;
  logic [N_CH-1:0]   err_out;
  logic [N_CH-1:0]   err_sticky;
  logic [2*N_CH-1:0] link_state;
  logic              link_bad_any;
  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic              rd_valid;
  logic              rd_err;
  logic [CNT_W+2:0]  rd_data;

  modport master (
    output err_in, send_err, clr_cnt, rd_req, rd_ch,
    input  err_out, err_sticky, link_state, link_bad_any, rd_valid, rd_err, rd_data
  );

  modport slave (
    input  err_in, send_err, clr_cnt, rd_req, rd_ch,
    output err_out, err_sticky, link_state, link_bad_any, rd_valid, rd_err, rd_data
  );
endinterface

// File: rtl/tlk_error_monitor.sv
// Per-channel TLK link error monitor: sampled error bit, sticky flag, saturating counter,
// link-health FSM per channel, and a single-cycle status read port.
module tlk_error_monitor #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned RUN_W    = 8,
  parameter int unsigned BAD_THR  = 4,
  parameter int unsigned GOOD_THR = 8
) (
  input logic                clk,
  input logic                reset,
  tlk_error_monitor_if.slave bus
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StOk = 2'b00, StWarn = 2'b01, StBad = 2'b10} link_state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [RUN_W-1:0] RunMax  = '1;
  localparam logic [RUN_W-1:0] BadThr  = RUN_W'(BAD_THR);
  localparam logic [RUN_W-1:0] GoodThr = RUN_W'(GOOD_THR);

  logic [CNT_W-1:0] cnt_q      [N_CH];
  logic [CNT_W-1:0] cnt_d      [N_CH];
  logic [RUN_W-1:0] bad_run_q  [N_CH];
  logic [RUN_W-1:0] bad_run_d  [N_CH];
  logic [RUN_W-1:0] good_run_q [N_CH];
  logic [RUN_W-1:0] good_run_d [N_CH];
  link_state_e      state_q    [N_CH];
  link_state_e      state_d    [N_CH];
  logic [N_CH-1:0]  err_out_q, err_out_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic             bad_any_q, bad_any_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic [CNT_W+2:0] rd_data_q, rd_data_d;
  logic [CH_W-1:0]  rd_idx;

  // Clear is applied first so that a coincident error sample counts from zero.
  always_comb begin
    err_out_d = err_out_q;
    sticky_d  = sticky_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]      = cnt_q[i];
      bad_run_d[i]  = bad_run_q[i];
      good_run_d[i] = good_run_q[i];
      state_d[i]    = state_q[i];
      if (bus.clr_cnt) begin
        cnt_d[i]    = '0;
        sticky_d[i] = 1'b0;
      end
      if (bus.send_err[i]) begin
        err_out_d[i] = bus.err_in[i];
        if (bus.err_in[i]) begin
          sticky_d[i]   = 1'b1;
          good_run_d[i] = '0;
          if (cnt_d[i] != CntMax) cnt_d[i] = cnt_d[i] + CNT_W'(1);
          if (bad_run_q[i] != RunMax) bad_run_d[i] = bad_run_q[i] + RUN_W'(1);
          if (bad_run_d[i] >= BadThr) begin
            state_d[i] = StBad;
          end else if (state_q[i] == StOk) begin
            state_d[i] = StWarn;
          end
        end else begin
          bad_run_d[i] = '0;
          if (good_run_q[i] != RunMax) good_run_d[i] = good_run_q[i] + RUN_W'(1);
          if (state_q[i] != StOk && good_run_d[i] >= GoodThr) state_d[i] = StOk;
        end
      end
    end
  end

  // Reads see the registered state, i.e. the values before this cycle's updates.
  always_comb begin
    bad_any_d  = 1'b0;
    rd_valid_d = bus.rd_req;
    rd_err_d   = 1'b0;
    rd_data_d  = '0;
    rd_idx     = bus.rd_ch;
    for (int i = 0; i < N_CH; i++) begin
      if (state_q[i] == StBad) bad_any_d = 1'b1;
    end
    if (bus.rd_req) begin
      if (32'(rd_idx) >= N_CH) begin
        rd_err_d = 1'b1;
      end else begin
        rd_data_d = {state_q[rd_idx], sticky_q[rd_idx], cnt_q[rd_idx]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_out_q  <= '0;
      sticky_q   <= '0;
      bad_any_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]      <= '0;
        bad_run_q[i]  <= '0;
        good_run_q[i] <= '0;
        state_q[i]    <= StOk;
      end
    end else begin
      err_out_q  <= err_out_d;
      sticky_q   <= sticky_d;
      bad_any_q  <= bad_any_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        bad_run_q[i]  <= bad_run_d[i];
        good_run_q[i] <= good_run_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  always_comb begin
    bus.link_state = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.link_state[2*i +: 2] = state_q[i];
    end
  end

  assign bus.err_out      = err_out_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.link_bad_any = bad_any_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.rd_data      = rd_data_q;
endmodule

// File: tb/tb_tlk_error_monitor.sv
// Self-checking bench for tlk_error_monitor: directed scenarios then random traffic, all
// outputs compared every cycle against an integer reference model of the channel rules.
module tb_tlk_error_monitor;
  localparam int N  = 3;
  localparam int CW = 4;
  localparam int BT = 4;
  localparam int GT = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlk_error_monitor_if #(.N_CH(N), .CNT_W(CW)) bus ();

  tlk_error_monitor #(
    .N_CH(N), .CNT_W(CW), .RUN_W(8), .BAD_THR(BT), .GOOD_THR(GT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = OK, 1 = WARN, 2 = BAD
  int m_cnt[N], m_sticky[N], m_bad[N], m_good[N], m_st[N], m_eo[N];
  int m_any, m_rv, m_re, m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int c;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_sticky[i] = 0; m_bad[i] = 0; m_good[i] = 0; m_st[i] = 0; m_eo[i] = 0;
      end
      m_any = 0; m_rv = 0; m_re = 0; m_rd = 0;
      return;
    end
    c = int'(bus.rd_ch);
    m_rv = int'(bus.rd_req);
    m_re = (bus.rd_req && c >= N) ? 1 : 0;
    m_rd = (bus.rd_req && c < N) ? ((m_st[c] << (CW + 1)) | (m_sticky[c] << CW) | m_cnt[c]) : 0;
    m_any = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == 2) m_any = 1;
    for (int i = 0; i < N; i++) begin
      if (bus.clr_cnt) begin
        m_cnt[i] = 0; m_sticky[i] = 0;
      end
      if (bus.send_err[i]) begin
        m_eo[i] = int'(bus.err_in[i]);
        if (bus.err_in[i]) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_sticky[i] = 1;
          m_bad[i] = (m_bad[i] < 255) ? m_bad[i] + 1 : 255;
          m_good[i] = 0;
          if (m_bad[i] >= BT) m_st[i] = 2;
          else if (m_st[i] == 0) m_st[i] = 1;
        end else begin
          m_good[i] = (m_good[i] < 255) ? m_good[i] + 1 : 255;
          m_bad[i] = 0;
          if (m_good[i] >= GT) m_st[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]   eo, st;
    logic [2*N-1:0] ls;
    for (int i = 0; i < N; i++) begin
      eo[i] = m_eo[i][0];
      st[i] = m_sticky[i][0];
      ls[2*i +: 2] = m_st[i][1:0];
    end
    check("err_out", 32'(bus.err_out), 32'(eo));
    check("err_sticky", 32'(bus.err_sticky), 32'(st));
    check("link_state", 32'(bus.link_state), 32'(ls));
    check("link_bad_any", 32'(bus.link_bad_any), m_any);
    check("rd_valid", 32'(bus.rd_valid), m_rv);
    check("rd_err", 32'(bus.rd_err), m_re);
    check("rd_data", 32'(bus.rd_data), m_rd);
  endtask

  task automatic step(input logic rst, input logic [N-1:0] send, input logic [N-1:0] err,
                      input logic clr, input logic rq, input logic [1:0] ch);
    reset = rst;
    bus.send_err = send;
    bus.err_in = err;
    bus.clr_cnt = clr;
    bus.rd_req = rq;
    bus.rd_ch = ch;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [2:0] r_send, r_err;
    reset = 1'b1;
    bus.send_err = '0; bus.err_in = '0; bus.clr_cnt = 1'b0; bus.rd_req = 1'b0; bus.rd_ch = '0;

    // Reset state
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(1, 3'b111, 3'b111, 1, 1, 0);
    check("reset_link_state", 32'(bus.link_state), 0);
    check("reset_err_out", 32'(bus.err_out), 0);

    // First sample: ch0 error, ch2 clean
    step(0, 3'b101, 3'b001, 0, 0, 0);
    check("t1_err_out", 32'(bus.err_out), 32'b001);
    check("t1_sticky", 32'(bus.err_sticky), 32'b001);
    check("t1_link", 32'(bus.link_state), 32'b000001);
    step(0, 3'b000, 3'b000, 0, 1, 0);
    check("t1_cnt0", 32'(bus.rd_data), 32'b0110001);

    // ch1: 4 errors -> BAD, then 7 clean still BAD, 8th clean -> OK
    for (int k = 0; k < 4; k++) step(0, 3'b010, 3'b010, 0, 0, 0);
    check("ch1_bad", 32'(bus.link_state[3:2]), 2);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    check("bad_any_lag", 32'(bus.link_bad_any), 1);
    for (int k = 0; k < 7; k++) step(0, 3'b010, 3'b000, 0, 0, 0);
    check("ch1_still_bad", 32'(bus.link_state[3:2]), 2);
    step(0, 3'b010, 3'b000, 0, 0, 0);
    check("ch1_ok", 32'(bus.link_state[3:2]), 0);

    // Counter saturation on ch0, then clear together with an error sample
    for (int k = 0; k < 20; k++) step(0, 3'b001, 3'b001, 0, 0, 0);
    step(0, 3'b000, 3'b000, 0, 1, 0);
    check("cnt_sat", 32'(bus.rd_data[3:0]), 15);
    step(0, 3'b001, 3'b001, 1, 0, 0);
    step(0, 3'b000, 3'b000, 0, 1, 0);
    check("clr_vs_err", 32'(bus.rd_data[4:0]), 32'b10001);

    // ch2 alternating error/clean stays WARN
    for (int k = 0; k < 12; k++) step(0, 3'b100, (k % 2 == 0) ? 3'b100 : 3'b000, 0, 0, 0);
    check("ch2_warn", 32'(bus.link_state[5:4]), 1);

    // err_in toggling without strobes
    for (int k = 0; k < 6; k++) step(0, 3'b000, 3'(k), 0, 0, 0);

    // Back-to-back reads including out-of-range channel
    for (int k = 0; k < 4; k++) step(0, 3'b000, 3'b000, 0, 1, 2'(k));
    check("rd_oob_err", 32'(bus.rd_err), 1);
    check("rd_oob_data", 32'(bus.rd_data), 0);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    check("rd_idle", 32'(bus.rd_valid), 0);

    // Read coincident with an error sample returns the pre-update count
    step(0, 3'b010, 3'b010, 0, 1, 1);
    step(0, 3'b000, 3'b000, 0, 1, 1);

    // Mid-run reset with ch0 BAD and cnt 9
    step(1, 3'b000, 3'b000, 0, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 3'b001, 3'b001, 0, 0, 0);
    step(0, 3'b000, 3'b000, 0, 1, 0);
    check("pre_reset_ch0", 32'(bus.rd_data), 32'b1011001);
    step(1, 3'b001, 3'b001, 0, 1, 0);
    check("mid_reset_link", 32'(bus.link_state), 0);
    check("mid_reset_rd", 32'(bus.rd_valid), 0);
    step(0, 3'b001, 3'b001, 0, 0, 0);
    step(0, 3'b000, 3'b000, 0, 1, 0);
    check("post_reset_cnt", 32'(bus.rd_data), 32'b0110001);

    // Randomized traffic, alternating error-heavy and clean-heavy phases
    for (int k = 0; k < 1600; k++) begin
      r_send = 3'($urandom);
      r_err = ((k / 200) % 2 == 0) ? 3'($urandom | $urandom) : 3'($urandom & $urandom);
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, r_send, r_err,
           ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, 1'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
